// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/stream_bus.sv
// StreamBus valid/ready/data handshake shared by uart_tx (sink side) and uart_rx (source side).
interface stream_bus (
  input logic clk,
  input logic rst
);
  import uart_pkg::*;

  logic                   valid;
  logic                   ready;
  logic [UART_DATA_W-1:0] data;

  modport source (input clk, input rst, input ready, output valid, output data);
  modport sink   (input clk, input rst, input valid, input data, output ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RST_VAL.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver presenting bytes on a StreamBus source port.
// Define UART_RX_PARITY_EN to add an even-parity bit and the perr output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 8_000_000,
  parameter int BAUD   = 1_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  stream_bus.source bus,
  output logic      ferr,
  output logic      ovf
`ifdef UART_RX_PARITY_EN
  ,
  output logic      perr
`endif
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);

  if (CPB < 4) begin : g_bad_baud
    $error("uart_rx: CLK_HZ/BAUD must give at least 4 clocks per bit");
  end

  uart_rx_state_e         state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             idx, idx_n;
  logic [UART_DATA_W-1:0] sh, sh_n;
  logic                   rxs, rxs_prev;
  logic [1:0]             warm;
  logic                   expired, done, frame_err;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad, par_bad_n, par_fail;
`endif

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  assign expired = (cnt == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    sh_n      = sh;
    done      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    par_fail  = 1'b0;
`endif
    if (state != IDLE && state != BREAK && !expired) cnt_n = cnt - 1'b1;
    unique case (state)
      IDLE: if (rxs_prev && !rxs) begin
        state_n = START;
        cnt_n   = HALF_LOAD;
      end
      START: if (expired) begin
        if (rxs) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          idx_n   = 3'd0;
          cnt_n   = FULL_LOAD;
        end
      end
      DATA: if (expired) begin
        sh_n  = {rxs, sh[UART_DATA_W-1:1]};
        idx_n = idx + 3'd1;
        cnt_n = FULL_LOAD;
`ifdef UART_RX_PARITY_EN
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (expired) begin
        par_bad_n = rxs ^ (^sh);
        cnt_n     = FULL_LOAD;
        state_n   = STOP;
      end
`endif
      STOP: if (expired) begin
        if (!rxs) begin
          frame_err = 1'b1;
          state_n   = BREAK;
        end else begin
          // Leave mid stop bit so a back-to-back start edge is caught.
          state_n = IDLE;
`ifdef UART_RX_PARITY_EN
          par_fail = par_bad;
          done     = !par_bad;
`else
          done     = 1'b1;
`endif
        end
      end
      BREAK: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      warm     <= '0;
      rxs_prev <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      warm     <= {warm[0], 1'b1};
      // Synchronizer reset values fake an idle line; ignore rxs until they have flushed.
      rxs_prev <= warm[1] ? rxs : 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= par_bad_n;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid <= 1'b0;
      bus.data  <= '0;
      ferr      <= 1'b0;
      ovf       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      ferr <= frame_err;
      ovf  <= done && bus.valid && !bus.ready;
`ifdef UART_RX_PARITY_EN
      perr <= par_fail;
`endif
      if (done && !(bus.valid && !bus.ready)) begin
        bus.valid <= 1'b1;
        bus.data  <= sh;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a bit-serial line driver, a stream monitor and a byte scoreboard.
module tb_uart_rx;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic ferr, ovf;
`ifdef UART_RX_PARITY_EN
  logic perr;
  int   perr_cnt = 0;
`endif

  always #5 clk = ~clk;

  stream_bus sb (.clk(clk), .rst(rst));

  uart_rx #(.CLK_HZ(8_000_000), .BAUD(1_000_000)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (sb.source),
    .ferr(ferr),
`ifdef UART_RX_PARITY_EN
    .perr(perr),
`endif
    .ovf (ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: everything observed on the negative edge, away from the active edge.
  int         cyc = 0;
  int         ferr_cnt = 0, ovf_cnt = 0, vhigh_cnt = 0, rise_cyc = 0;
  logic       vprev = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb.valid) vhigh_cnt++;
    if (sb.valid && sb.ready) got_q.push_back(sb.data);
    if (sb.valid && !vprev) rise_cyc = cyc;
    vprev = sb.valid;
    if (ferr) ferr_cnt++;
    if (ovf) ovf_cnt++;
`ifdef UART_RX_PARITY_EN
    if (perr) perr_cnt++;
`endif
  end

  // Line driver; the invariant between calls is "1 time unit after a rising edge".
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic even_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return logic'(ones % 2);
  endfunction

  // Reference model: every well-formed frame whose byte is not dropped shows up once, in order.
  logic [7:0] exp_q[$];
  int         rd = 0;

  task automatic expect_bytes(input string tag);
    check({tag, "_count"}, got_q.size() - rd, exp_q.size());
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      check({tag, "_data"}, got_q[rd], exp_q.pop_front());
      rd++;
    end
    rd = got_q.size();
    exp_q.delete();
  endtask

  int f0, o0, v0, t0;

  initial begin
    sb.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", sb.valid, 0);
    check("rst_data", sb.data, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    idle(20);

    // Single frame, consumer always ready.
    v0 = vhigh_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
    t0 = cyc;
    send_frame(8'hAB, 1'b1, even_par(8'hAB));
    idle(10);
    exp_q.push_back(8'hAB);
    expect_bytes("ab");
    check("ab_valid_cycles", vhigh_cnt - v0, 1);
    check("ab_latency_ok", (rise_cyc - t0 >= 77 && rise_cyc - t0 <= 83), 1);
    check("ab_ferr", ferr_cnt - f0, 0);
    check("ab_ovf", ovf_cnt - o0, 0);

    // Short glitch must not start a frame.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(120);
    expect_bytes("glitch");
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Framing error followed by a held-low line, then a good frame.
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, even_par(8'h55));
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(3 * CPB);
    check("brk_ferr_once", ferr_cnt - f0, 1);
    expect_bytes("brk_novalid");
    send_frame(8'h3C, 1'b1, even_par(8'h3C));
    idle(10);
    exp_q.push_back(8'h3C);
    expect_bytes("after_brk");

    // Overflow with a stalled consumer and back-to-back frames.
    @(posedge clk);
    #1;
    sb.ready = 1'b0;
    o0 = ovf_cnt;
    send_frame(8'h11, 1'b1, even_par(8'h11));
    send_frame(8'h22, 1'b1, even_par(8'h22));
    idle(20);
    check("ovf_pulse", ovf_cnt - o0, 1);
    check("ovf_hold_valid", sb.valid, 1);
    check("ovf_hold_data", sb.data, 8'h11);
    sb.ready = 1'b1;
    idle(5);
    exp_q.push_back(8'h11);
    expect_bytes("ovf_drain");
    check("ovf_drained", sb.valid, 0);

    // Reset in the middle of data bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_data", sb.data, 0);
    check("midrst_valid", sb.valid, 0);
    check("midrst_ferr", ferr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    send_frame(8'h0F, 1'b1, even_par(8'h0F));
    idle(10);
    exp_q.push_back(8'h0F);
    expect_bytes("midrst_next");

    // Line already low when reset releases: no start until a real falling edge.
    f0 = ferr_cnt;
    rx = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    idle(120);
    expect_bytes("lowrst");
    check("lowrst_ferr", ferr_cnt - f0, 0);

    // Randomized bytes with random idle gaps, including zero-gap back-to-back frames.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, even_par(b));
      exp_q.push_back(b);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 20));
    end
    idle(100);
    expect_bytes("rand");
    check("rand_ferr", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(10);
    exp_q.push_back(8'h07);
    expect_bytes("par_ok");
    o0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(10);
    check("par_bad_perr", perr_cnt - o0, 1);
    expect_bytes("par_bad");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
